// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: supervisor-aware fetch PC, DEPTH-entry {pc, instr} queue toward decode,
// reset/ILLOP/IRQ/redirect steering and EPC capture. Define FETCH_BYPASS_EN for zero-latency ROM bypass.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcadd4,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc_illop,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] epc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] entry_pc_q    [DEPTH];
  logic [31:0] entry_instr_q [DEPTH];

  logic        irq_take;
  logic        flush;
  logic        q_empty;
  logic        q_full;
  logic        bypass_active;
  logic        bypass_take;
  logic        pop;
  logic        push;
  logic        advance;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [31:0] fpc_inc;

  // Supervisor mode (fpc[31]) masks interrupts; a held irq is re-evaluated every cycle.
  always_comb begin
    irq_take   = irq & ~fpc_q[31];
    flush      = exc_illop | irq_take | redir_valid;
    q_empty    = (count_q == '0);
    q_full     = (count_q == DEPTH_C);
    head_pc    = entry_pc_q[rd_ptr_q];
    head_instr = entry_instr_q[rd_ptr_q];
    fpc_inc    = {fpc_q[31], fpc_q[30:0] + 31'd4};
  end

`ifdef FETCH_BYPASS_EN
  always_comb begin
    bypass_active = q_empty & ~flush & ~reset;
  end
`else
  always_comb begin
    bypass_active = 1'b0;
  end
`endif

  always_comb begin
    if_valid  = ~reset & ~flush & (~q_empty | bypass_active);
    if_pc     = bypass_active ? fpc_q      : head_pc;
    if_instr  = bypass_active ? imem_rdata : head_instr;
    if_pcadd4 = {if_pc[31], if_pc[30:0] + 31'd4};
    imem_addr = fpc_q;
    epc       = epc_q;
    irq_ack   = ~reset & ~exc_illop & irq_take;
  end

  // A bypassed word handed straight to decode is never enqueued, but the PC still advances.
  always_comb begin
    pop         = if_valid & if_ready & ~q_empty;
    bypass_take = bypass_active & if_ready;
    push        = ~reset & ~flush & ~bypass_take & (~q_full | pop);
    advance     = push | bypass_take;
  end

  always_comb begin
    fpc_d    = fpc_q;
    epc_d    = epc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (reset) begin
      fpc_d    = RESET_PC;
      epc_d    = '0;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (exc_illop) begin
        fpc_d = ILLOP_PC;
      end else if (irq_take) begin
        fpc_d = XADR_PC;
        epc_d = q_empty ? fpc_q : head_pc;
      end else begin
        fpc_d = redir_pc;
      end
    end else begin
      if (advance) begin
        fpc_d = fpc_inc;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    fpc_q    <= fpc_d;
    epc_q    <= epc_d;
    count_q  <= count_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
  end

  // Queue payload needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_pc_q[wr_ptr_q]    <= fpc_q;
      entry_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);
  assert property (@(posedge clk) disable iff (reset) !(push && q_full && !pop));
  assert property (@(posedge clk) disable iff (reset) !(pop && q_empty));

endmodule
